// File: rtl/data_memory_mc_if.sv
// rtl/data_memory_mc_if.sv - request/response bus between a load/store master and data_memory_mc
interface data_memory_mc_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_i;
    logic                  we_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W/8-1:0]   be_i;
    logic [DATA_W-1:0]     data_i;
    logic                  ready_o;
    logic                  ack_o;
    logic [DATA_W-1:0]     data_o;
    logic                  err_o;

    modport master (
        output req_i, we_i, addr_i, be_i, data_i,
        input  ready_o, ack_o, data_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, be_i, data_i,
        output ready_o, ack_o, data_o, err_o
    );
endinterface

// File: rtl/data_memory_mc.sv
// rtl/data_memory_mc.sv - multi-cycle byte-lane data memory with fixed access latency
// Optional out-of-range detection enabled by defining DMEM_ADDR_CHECK_EN.
module data_memory_mc #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    data_memory_mc_if.slave  bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NB-1:0]     be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_we;
    logic [IDX_W-1:0]  idx;
    logic              oor;
    logic              unused_addr;

    // Byte-offset bits are dropped; without range checking the upper bits wrap.
    assign idx         = IDX_W'(addr_q >> OFF_W);
    assign unused_addr = ^addr_q;

`ifdef DMEM_ADDR_CHECK_EN
    assign oor = (addr_q >> (OFF_W + IDX_W)) != '0;
`else
    assign oor = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    we_d    = bus.we_i;
                    addr_d  = bus.addr_i;
                    be_d    = bus.be_i;
                    wdata_d = bus.data_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    ready_d = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    ack_d   = 1'b1;
                    err_d   = oor;
                    if (we_q) begin
                        mem_we = !oor;
                    end else begin
                        rdata_d = oor ? '0 : mem[idx];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A reset on the completion edge must not commit the write.
        if (rst_i) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int k = 0; k < NB; k++) begin
                if (be_q[k]) begin
                    mem[idx][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.data_o  = rdata_q;
endmodule
